// File: rtl/prog_mod_counter.sv
// Programmable-modulus up/down counter with an IDLE/RUN/DONE run controller.
// Optional macro PROG_MOD_COUNTER_WRAP_CNT_EN adds a saturating wrap_cnt output.
module prog_mod_counter #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MOD_RST = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic             up_dn,
  input  logic [WIDTH-1:0] mod_val,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             busy,
`ifdef PROG_MOD_COUNTER_WRAP_CNT_EN
  output logic             done,
  output logic [WIDTH-1:0] wrap_cnt
`else
  output logic             done
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [1:0]       state, state_nx;
  logic [WIDTH-1:0] m_s, m_s_nx, q_nx;
  logic [WIDTH-1:0] mod_m1, cap_m1;
  logic             tc_nx, start_acc, terminal;

  // M-1 in WIDTH bits; a modulus of 0 (2^WIDTH) naturally yields all-ones
  assign mod_m1   = m_s - ONE;
  assign cap_m1   = mod_val - ONE;
  assign terminal = up_dn ? (q == mod_m1) : (q == '0);

  always_comb begin
    state_nx  = state;
    m_s_nx    = m_s;
    q_nx      = q;
    tc_nx     = 1'b0;
    start_acc = 1'b0;
    if (load) begin
      m_s_nx = mod_val;
      q_nx   = ((mod_val != '0) && (load_val >= mod_val)) ? cap_m1 : load_val;
    end else if (stop && (state == RUN)) begin
      state_nx = IDLE;
    end else if (start && (state != RUN)) begin
      start_acc = 1'b1;
      m_s_nx    = mod_val;
      q_nx      = up_dn ? '0 : cap_m1;
      state_nx  = RUN;
    end else if ((state == RUN) && en) begin
      tc_nx = terminal;
      if (terminal && mode)
        state_nx = DONE;
      else if (terminal)
        q_nx = up_dn ? '0 : mod_m1;
      else
        q_nx = up_dn ? (q + ONE) : (q - ONE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      m_s   <= WIDTH'(MOD_RST);
      q     <= '0;
      tc    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      m_s   <= m_s_nx;
      q     <= q_nx;
      tc    <= tc_nx;
      busy  <= (state_nx == RUN);
      done  <= (state_nx == DONE);
    end
  end

`ifdef PROG_MOD_COUNTER_WRAP_CNT_EN
  // Advances together with tc so both reflect the same terminal event
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      wrap_cnt <= '0;
    else if (start_acc)
      wrap_cnt <= '0;
    else if (tc_nx && (wrap_cnt != '1))
      wrap_cnt <= wrap_cnt + ONE;
  end
`endif

endmodule

// File: tb/tb_prog_mod_counter.sv
// Scoreboard bench for prog_mod_counter: directed scenarios plus random traffic
// against an arithmetic reference model; honours PROG_MOD_COUNTER_WRAP_CNT_EN.
module tb_prog_mod_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0, start = 1'b0, stop = 1'b0, mode = 1'b0, up_dn = 1'b1, load = 1'b0;
  logic [3:0] mod_val = 4'd0, load_val = 4'd0;
  logic [3:0] q;
  logic       tc, busy, done;
`ifdef PROG_MOD_COUNTER_WRAP_CNT_EN
  logic [3:0] wrap_cnt;
`endif

  prog_mod_counter #(.WIDTH(4), .MOD_RST(10)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .stop(stop), .mode(mode),
    .up_dn(up_dn), .mod_val(mod_val), .load(load), .load_val(load_val),
    .q(q), .tc(tc), .busy(busy),
`ifdef PROG_MOD_COUNTER_WRAP_CNT_EN
    .done(done), .wrap_cnt(wrap_cnt)
`else
    .done(done)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int q;
    bit tc;
    bit busy;
    bit done;
    int wc;
  } exp_t;

  exp_t exp_q[$];
  event mon_ev;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: phase 0 idle, 1 run, 2 done; M is the true modulus 1..16
  int m_phase, m_q, m_M, m_wc;
  bit m_tc;

  function automatic int modulus(input logic [3:0] v);
    return (v == 4'd0) ? 16 : int'(v);
  endfunction

  task automatic model_reset();
    m_phase = 0; m_q = 0; m_M = 10; m_wc = 0; m_tc = 0;
  endtask

  task automatic model_step();
    m_tc = 0;
    if (load) begin
      m_M = modulus(mod_val);
      m_q = (int'(load_val) >= m_M) ? m_M - 1 : int'(load_val);
    end else if (stop && m_phase == 1) begin
      m_phase = 0;
    end else if (start && m_phase != 1) begin
      m_M = modulus(mod_val);
      m_q = up_dn ? 0 : m_M - 1;
      m_phase = 1;
      m_wc = 0;
    end else if (m_phase == 1 && en) begin
      m_tc = up_dn ? (m_q == m_M - 1) : (m_q == 0);
      if (m_tc) m_wc = (m_wc < 15) ? m_wc + 1 : 15;
      if (m_tc && mode) m_phase = 2;
      else if (up_dn) m_q = (m_q + 1) % m_M;
      else m_q = (m_q + m_M - 1) % m_M;
    end
  endtask

  task automatic push_expect();
    exp_t e;
    e.q = m_q; e.tc = m_tc; e.busy = (m_phase == 1); e.done = (m_phase == 2); e.wc = m_wc;
    exp_q.push_back(e);
    -> mon_ev;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    push_expect();
    @(negedge clk);
    start = 1'b0; stop = 1'b0; load = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic go(input logic [3:0] m, input logic md, input logic up);
    mod_val = m; mode = md; up_dn = up; en = 1'b1; start = 1'b1;
    tick();
  endtask

  task automatic rst_pulse();
    #2 rst = 1'b1;
    model_reset();
    push_expect();
    #2 rst = 1'b0;
  endtask

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  // Monitor: pops one expectation per presented output sample
  initial begin
    exp_t e;
    forever begin
      @(mon_ev);
      #1;
      if (exp_q.size() == 0) begin
        chk("queue_underflow", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("q", int'(q), e.q);
        chk("tc", int'(tc), int'(e.tc));
        chk("busy", int'(busy), int'(e.busy));
        chk("done", int'(done), int'(e.done));
`ifdef PROG_MOD_COUNTER_WRAP_CNT_EN
        chk("wrap_cnt", int'(wrap_cnt), e.wc);
`endif
      end
    end
  end

  initial begin
    model_reset();
    #1 push_expect();
    @(negedge clk);
    rst = 1'b0;

    // Continuous up, M=5
    go(4'd5, 1'b0, 1'b1);
    ticks(13);
    // One-shot down, M=6, then restart
    go(4'd6, 1'b1, 1'b0);
    ticks(8);
    go(4'd6, 1'b1, 1'b0);
    ticks(3);
    // Clamped load at q=3 with competing start/stop
    go(4'd5, 1'b0, 1'b1);
    ticks(3);
    load = 1'b1; load_val = 4'd9; start = 1'b1; stop = 1'b1;
    tick();
    ticks(2);
    // Async reset mid-run, then enable without start
    go(4'd8, 1'b0, 1'b1);
    ticks(2);
    rst_pulse();
    ticks(4);
    // Full binary wrap, modulus change ignored mid-run
    go(4'd0, 1'b0, 1'b1);
    ticks(10);
    mod_val = 4'd3;
    ticks(12);
    stop = 1'b1;
    tick();
    // M=1 and M=2 saturation run
    go(4'd1, 1'b0, 1'b0);
    ticks(4);
    stop = 1'b1;
    tick();
    go(4'd2, 1'b0, 1'b1);
    ticks(40);
    go(4'd2, 1'b0, 1'b1);
    ticks(2);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      en       = ($urandom_range(3) != 0);
      start    = ($urandom_range(7) == 0);
      stop     = ($urandom_range(31) == 0);
      load     = ($urandom_range(31) == 0);
      load_val = 4'($urandom_range(15));
      mod_val  = 4'($urandom_range(15));
      if ($urandom_range(15) == 0) mode = ~mode;
      if ($urandom_range(15) == 0) up_dn = ~up_dn;
      if ($urandom_range(199) == 0) rst_pulse();
      tick();
    end

    ticks(2);
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
